// File: rtl/ssd_mux_driver.sv
// Time-multiplexed seven-segment driver with a shadow/display double buffer.
// Define SSD_LZ_SUPPRESS_EN to blank leading zero digits.
module ssd_mux_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 50000,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [4*NUM_DIGITS-1:0] DigitsIn,
   input  logic [NUM_DIGITS-1:0]   DPIn,
   input  logic [NUM_DIGITS-1:0]   BlankIn,
   input  logic                    LoadIn,
   output logic [6:0]              SSDOut,
   output logic                    DPOut,
   output logic [NUM_DIGITS-1:0]   AnodeOut,
   output logic                    PendingOut,
   output logic                    FrameTick
);

   localparam int CNT_W = $clog2(PRESCALE);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic INV = (ACTIVE_LOW != 0);

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] digits;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blank;
   } frame_t;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   frame_t                shadow_q, shadow_d;
   frame_t                disp_q, disp_d;
   logic                  pending_q, pending_d;
   logic                  frame_q, frame_d;
   logic [6:0]            ssd_q, ssd_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;

   logic                  slot_tick;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic [NUM_DIGITS-1:0] anode_hot;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'h0:    seg_decode = 7'h3F;
         4'h1:    seg_decode = 7'h06;
         4'h2:    seg_decode = 7'h5B;
         4'h3:    seg_decode = 7'h4F;
         4'h4:    seg_decode = 7'h66;
         4'h5:    seg_decode = 7'h6D;
         4'h6:    seg_decode = 7'h7D;
         4'h7:    seg_decode = 7'h07;
         4'h8:    seg_decode = 7'h7F;
         4'h9:    seg_decode = 7'h6F;
         4'hA:    seg_decode = 7'h77;
         4'hB:    seg_decode = 7'h7C;
         4'hC:    seg_decode = 7'h39;
         4'hD:    seg_decode = 7'h5E;
         4'hE:    seg_decode = 7'h79;
         default: seg_decode = 7'h71;
      endcase
   endfunction

`ifdef SSD_LZ_SUPPRESS_EN
   logic lz_run;

   // A zero stays dark while every more-significant digit is also zero,
   // unless its own decimal point is lit; digit 0 always shows.
   always_comb begin
      lz_blank = '0;
      lz_run   = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         lz_run      = lz_run && (disp_q.digits[4*k +: 4] == 4'h0);
         lz_blank[k] = lz_run && !disp_q.dp[k];
      end
   end
`else
   always_comb lz_blank = '0;
`endif

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      anode_hot = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         anode_hot[k] = (idx_q == IDX_W'(k));
         if (idx_q == IDX_W'(k)) begin
            cur_nib   = disp_q.digits[4*k +: 4];
            cur_dp    = disp_q.dp[k];
            cur_blank = disp_q.blank[k] | lz_blank[k];
         end
      end
   end

   always_comb begin
      // NOTE: every _d takes its hold value first so no branch can infer a latch.
      slot_tick = (cnt_q == CNT_LAST);
      cnt_d     = slot_tick ? '0 : cnt_q + CNT_W'(1);
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      disp_d    = disp_q;
      pending_d = pending_q;
      frame_d   = 1'b0;
      ssd_d     = ssd_q;
      dp_d      = dp_q;
      anode_d   = anode_q;

      if (LoadIn) begin
         shadow_d  = '{digits: DigitsIn, dp: DPIn, blank: BlankIn};
         pending_d = 1'b1;
      end

      if (slot_tick) begin
         ssd_d   = (cur_blank ? 7'h00 : seg_decode(cur_nib)) ^ {7{INV}};
         dp_d    = (cur_dp & ~cur_blank) ^ INV;
         anode_d = anode_hot ^ {NUM_DIGITS{INV}};
         if (idx_q == IDX_LAST) begin
            // Frame boundary: the display buffer only ever changes here.
            idx_d   = '0;
            disp_d  = shadow_q;
            frame_d = 1'b1;
            if (!LoadIn) pending_d = 1'b0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         // NOTE: shadow and display are reset as well, so pending data is dropped.
         cnt_q     <= '0;
         idx_q     <= '0;
         shadow_q  <= '0;
         disp_q    <= '0;
         pending_q <= 1'b0;
         frame_q   <= 1'b0;
         ssd_q     <= {7{INV}};
         dp_q      <= INV;
         anode_q   <= {NUM_DIGITS{INV}};
      end else begin
         // NOTE: non-blocking so every register updates from the same pre-edge values.
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
         frame_q   <= frame_d;
         ssd_q     <= ssd_d;
         dp_q      <= dp_d;
         anode_q   <= anode_d;
      end
   end

   assign SSDOut     = ssd_q;
   assign DPOut      = dp_q;
   assign AnodeOut   = anode_q;
   assign PendingOut = pending_q;
   assign FrameTick  = frame_q;

endmodule
